// File: rtl/pulse_frequency_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and reports the total.
// Optional PULSE_FREQ_PERIOD_EN adds an edge-to-edge period measurement.
module pulse_frequency_meter #(
  parameter int unsigned FREQUENCY_IN = 50_000_000,
  parameter int unsigned GATE_CYCLES  = 50_000_000,
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sig_in,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] freq_out,
  output logic                   freq_valid,
  output logic                   overflow,
  output logic                   busy
`ifdef PULSE_FREQ_PERIOD_EN
  ,
  output logic [31:0]            period_out,
  output logic                   period_valid
`endif
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  if (SYNC_STAGES < 2 || GATE_CYCLES < 2 || FREQUENCY_IN == 0) begin : g_bad_param
    $error("pulse_frequency_meter: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, ARM, GATE, REPORT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [GW-1:0]          gate_cnt_q, gate_cnt_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] freq_out_q, freq_out_d;
  logic                   overflow_q, overflow_d;
  logic                   sig_rise;

  // Synchronizer chain followed by one history flop for edge detection
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
    hist_d   = sync_q[SYNC_STAGES-1];
    sig_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = '0;
    edge_cnt_d = '0;
    ovf_d      = 1'b0;
    freq_out_d = freq_out_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE:   if (enable) state_d = ARM;
      ARM:    state_d = enable ? GATE : IDLE;
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = edge_cnt_q;
          ovf_d      = ovf_q;
          if (sig_rise) begin
            if (edge_cnt_q == {COUNT_WIDTH{1'b1}}) ovf_d = 1'b1;
            else edge_cnt_d = edge_cnt_q + 1'b1;
          end
          // The final gate cycle's edge is folded into the published result
          if (gate_cnt_q == GATE_LAST) begin
            state_d    = REPORT;
            gate_cnt_d = '0;
            freq_out_d = edge_cnt_d;
            overflow_d = ovf_d;
            edge_cnt_d = '0;
            ovf_d      = 1'b0;
          end
        end
      end
      REPORT: state_d = enable ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      freq_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      freq_out_q <= freq_out_d;
      overflow_q <= overflow_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign overflow   = overflow_q;
  assign freq_valid = (state_q == REPORT);
  assign busy       = (state_q == ARM) || (state_q == GATE);

`ifdef PULSE_FREQ_PERIOD_EN
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] period_out_q, period_out_d;
  logic        per_seen_q, per_seen_d;
  logic        period_valid_q, period_valid_d;

  // Free-running edge-to-edge counter, independent of the gate state machine
  always_comb begin
    per_cnt_d      = (per_cnt_q == 32'hFFFF_FFFF) ? per_cnt_q : per_cnt_q + 32'd1;
    period_out_d   = period_out_q;
    per_seen_d     = per_seen_q;
    period_valid_d = 1'b0;
    if (sig_rise) begin
      per_cnt_d  = 32'd1;
      per_seen_d = 1'b1;
      if (per_seen_q) begin
        period_out_d   = per_cnt_q;
        period_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q      <= '0;
      period_out_q   <= '0;
      per_seen_q     <= 1'b0;
      period_valid_q <= 1'b0;
    end else begin
      per_cnt_q      <= per_cnt_d;
      period_out_q   <= period_out_d;
      per_seen_q     <= per_seen_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
`endif

endmodule

// File: tb/tb_pulse_frequency_meter.sv
// Directed bench for pulse_frequency_meter: a 32-bit instance and a 4-bit saturating instance,
// both with a 1000-cycle gate window.
module tb_pulse_frequency_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig, enable;
  logic [31:0] freq_out;
  logic        freq_valid, overflow, busy;
  logic        sig4, en4;
  logic [3:0]  fo4;
  logic        fv4, ov4, busy4;
`ifdef PULSE_FREQ_PERIOD_EN
  logic [31:0] period_out;
  logic        period_valid;
  logic [31:0] p_out4;
  logic        p_vld4;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int mode4  = 0;
  int ph     = 0;

  always #5 clk = ~clk;

  pulse_frequency_meter #(.GATE_CYCLES(1000), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .sig_in(sig), .enable(enable),
    .freq_out(freq_out), .freq_valid(freq_valid), .overflow(overflow), .busy(busy)
`ifdef PULSE_FREQ_PERIOD_EN
    , .period_out(period_out), .period_valid(period_valid)
`endif
  );

  pulse_frequency_meter #(.GATE_CYCLES(1000), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig4), .enable(en4),
    .freq_out(fo4), .freq_valid(fv4), .overflow(ov4), .busy(busy4)
`ifdef PULSE_FREQ_PERIOD_EN
    , .period_out(p_out4), .period_valid(p_vld4)
`endif
  );

  // Stimulus generator: 0 = idle low, 1 = pulse every 10, 2 = 2/2 square, 3 = pulse every 37
  initial begin
    sig  = 1'b0;
    sig4 = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        1:       sig = (ph % 10 == 0);
        2:       sig = (ph % 4 < 2);
        3:       sig = (ph % 37 == 0);
        default: sig = 1'b0;
      endcase
      sig4 = (mode4 != 0) ? (ph % 4 < 2) : 1'b0;
      ph++;
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!freq_valid && n < 3000);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; en4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL reset_freq_out got %0d want 0", freq_out); end
    checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL reset_freq_valid got %b want 0", freq_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fo4 !== 4'd0 || busy4 !== 1'b0) begin errors++; $display("FAIL reset_dut4 got fo4=%0d busy4=%b want 0/0", fo4, busy4); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_latency_zero();
    int n;
    mode = 0;
    enable = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %b want 1", busy); end
    wait_valid(n);
    n++;
    checks++; if (n !== 1002) begin errors++; $display("FAIL first_latency got %0d want 1002", n); end
    checks++; if (freq_out !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL zero_count got %0d/%b want 0/0", freq_out, overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL report_busy got %b want 0", busy); end
    wait_valid(n);
    checks++; if (n !== 1001) begin errors++; $display("FAIL zero_interval got %0d want 1001", n); end
    checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL zero_count2 got %0d want 0", freq_out); end
  endtask

  task automatic test_pulse_rate();
    int n;
    mode = 1;
    wait_valid(n);
    for (int k = 0; k < 2; k++) begin
      wait_valid(n);
      checks++; if (n !== 1001) begin errors++; $display("FAIL pulse_interval[%0d] got %0d want 1001", k, n); end
      checks++; if (freq_out !== 32'd100) begin errors++; $display("FAIL pulse_count[%0d] got %0d want 100", k, freq_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pulse_ovf[%0d] got %b want 0", k, overflow); end
      @(negedge clk);
      checks++; if (freq_valid !== 1'b0) begin errors++; $display("FAIL valid_width[%0d] got %b want 0", k, freq_valid); end
      repeat (1000) @(negedge clk);
      checks++; if (freq_valid !== 1'b1) begin errors++; $display("FAIL valid_period[%0d] got %b want 1", k, freq_valid); end
    end
  endtask

  task automatic test_abort();
    int n;
    int seen;
    repeat (500) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_busy got %b want 1", busy); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    seen = 0;
    repeat (1200) begin
      @(negedge clk);
      if (freq_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", seen); end
    checks++; if (freq_out !== 32'd100) begin errors++; $display("FAIL abort_retain got %0d want 100", freq_out); end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy got %b want 1", busy); end
    wait_valid(n);
    checks++; if (n !== 1001) begin errors++; $display("FAIL rearm_latency got %0d want 1001", n); end
    checks++; if (freq_out !== 32'd100) begin errors++; $display("FAIL rearm_count got %0d want 100", freq_out); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (700) @(negedge clk);
    checks++; if (freq_out !== 32'd100 || busy !== 1'b1) begin errors++; $display("FAIL pre_rst got %0d/%b want 100/1", freq_out, busy); end
    rst = 1'b1;
    #1;
    checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL mid_rst_freq_out got %0d want 0", freq_out); end
    checks++; if (busy !== 1'b0 || freq_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got %b%b%b want 000", busy, freq_valid, overflow); end
    @(negedge clk);
    rst = 1'b0;
    wait_valid(n);
    checks++; if (n !== 1002) begin errors++; $display("FAIL post_rst_latency got %0d want 1002", n); end
    checks++; if (freq_out !== 32'd100) begin errors++; $display("FAIL post_rst_count got %0d want 100", freq_out); end
  endtask

  task automatic test_saturation();
    int n;
    mode4 = 2;
    en4   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 900) mode4 = 0;
    end while (!fv4 && n < 3000);
    checks++; if (n !== 1002) begin errors++; $display("FAIL sat_latency got %0d want 1002", n); end
    checks++; if (fo4 !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", fo4); end
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", ov4); end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fv4 && n < 3000);
    checks++; if (n !== 1001) begin errors++; $display("FAIL sat_interval got %0d want 1001", n); end
    checks++; if (fo4 !== 4'd0 || ov4 !== 1'b0) begin errors++; $display("FAIL sat_clear got %0d/%b want 0/0", fo4, ov4); end
    en4 = 1'b0;
  endtask

`ifdef PULSE_FREQ_PERIOD_EN
  task automatic test_period();
    int n;
    mode = 3;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!period_valid && n < 200);
      if (k >= 2) begin
        checks++; if (n !== 37) begin errors++; $display("FAIL period_gap[%0d] got %0d want 37", k, n); end
        checks++; if (period_out !== 32'd37) begin errors++; $display("FAIL period_out[%0d] got %0d want 37", k, period_out); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency_zero();
    test_pulse_rate();
    test_abort();
    test_reset_mid();
    test_saturation();
`ifdef PULSE_FREQ_PERIOD_EN
    test_period();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
